control_sequencer: RTL and testbench

Multi-cycle control unit for the RNBIP-2 datapath. It decodes the 8-bit opcode held in the instruction register and sequences the fetch, operand, execute and write-back cycles. It drives every datapath strobe: stack pointer, PC, register file, IR, flag register and ALU selects. It sits between the IR/flag outputs and the control inputs of the datapath in the processor top level.

---
 rtl/control_sequencer.sv | 163 ++++++++++++++++
 tb/tb_control_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control unit for the RNBIP-2 datapath: sequences fetch, operand,
// execute and write-back, decoding every datapath strobe from the state and IR.
module control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic [1:0] flags,
    input  logic       stall,
    output logic [1:0] rw,
    output logic       L_PC,
    output logic       I_PC,
    output logic       S11,
    output logic       S10,
    output logic [1:0] enab,
    output logic [2:0] reg_sel,
    output logic [1:0] mux_sel,
    output logic       L_IR,
    output logic       S_AL,
    output logic [3:0] S_AF,
    output logic       sel_a,
    output logic       sel_b,
    output logic       halted,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op;
    logic       jmp_ok;

    assign op = ir[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                ST_RST:     state_d = ST_FETCH;
                ST_FETCH:   state_d = ST_DECODE;
                ST_DECODE: begin
                    case (op)
                        4'h0:                state_d = (ir[3:0] == 4'h1) ? ST_HALT : ST_EXEC;
                        4'h1, 4'h2, 4'h3:    state_d = ST_OPERAND;
                        4'h4, 4'h5:          state_d = ST_EXEC;
                        default:             state_d = ir[3] ? ST_OPERAND : ST_EXEC;
                    endcase
                end
                ST_OPERAND: state_d = ST_EXEC;
                ST_EXEC:    state_d = (op >= 4'h6) ? ST_WB : ST_FETCH;
                ST_WB:      state_d = ST_FETCH;
                ST_HALT:    state_d = ST_HALT;
                default:    state_d = ST_RST;
            endcase
        end
    end

    // Flags are {c, z}; sampled live so a stalled JMP sees the post-stall value
    always_comb begin
        case (ir[2:0])
            3'b000:  jmp_ok = 1'b1;
            3'b001:  jmp_ok = flags[0];
            3'b010:  jmp_ok = ~flags[0];
            3'b011:  jmp_ok = flags[1];
            3'b100:  jmp_ok = ~flags[1];
            default: jmp_ok = 1'b0;
        endcase
    end

    always_comb begin
        rw      = '0;
        L_PC    = 1'b0;
        I_PC    = 1'b0;
        S11     = 1'b0;
        S10     = 1'b0;
        enab    = '0;
        reg_sel = '0;
        mux_sel = '0;
        L_IR    = 1'b0;
        S_AL    = 1'b0;
        S_AF    = '0;
        sel_a   = 1'b0;
        sel_b   = 1'b0;
        halted  = (state_q == ST_HALT);
        state_o = state_q;
        if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    L_IR = 1'b1;
                    I_PC = 1'b1;
                end
                ST_OPERAND: I_PC = 1'b1;
                ST_EXEC: begin
                    case (op)
                        4'h0: begin
                            if (ir[3:0] == 4'h2) begin
                                rw   = 2'b10;
                                L_PC = 1'b1;
                                S11  = 1'b1;
                            end
                        end
                        4'h1: begin
                            enab    = 2'b01;
                            reg_sel = ir[2:0];
                            mux_sel = 2'b01;
                        end
                        4'h2: begin
                            L_PC = jmp_ok;
                            S10  = jmp_ok;
                        end
                        4'h3: begin
                            rw   = 2'b01;
                            L_PC = 1'b1;
                            S10  = 1'b1;
                        end
                        4'h4: begin
                            rw      = 2'b01;
                            enab    = 2'b10;
                            reg_sel = ir[2:0];
                        end
                        4'h5: begin
                            rw      = 2'b10;
                            enab    = 2'b01;
                            reg_sel = ir[2:0];
                            mux_sel = 2'b10;
                        end
                        default: begin
                            S_AF  = op;
                            sel_a = 1'b1;
                            sel_b = ir[3];
                            if (!ir[3]) begin
                                enab    = 2'b10;
                                reg_sel = ir[2:0];
                            end
                        end
                    endcase
                end
                ST_WB: begin
                    S_AF  = op;
                    sel_a = 1'b1;
                    sel_b = ir[3];
                    S_AL  = 1'b1;
                    // CMP (0x7) updates flags only
                    if (op != 4'h7) enab = 2'b01;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes the expected
// output vector, and a negedge monitor pops and compares it against the DUT.
module tb_control_sequencer;

    localparam logic [2:0] S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_OPERAND = 3'd3, S_EXEC = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] rw;
        logic       l_pc;
        logic       i_pc;
        logic       s11;
        logic       s10;
        logic [1:0] enab;
        logic [2:0] reg_sel;
        logic [1:0] mux_sel;
        logic       l_ir;
        logic       s_al;
        logic [3:0] s_af;
        logic       sel_a;
        logic       sel_b;
        logic       halted;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir = '0;
    logic [1:0] flags = '0;
    logic       stall = 1'b0;
    logic [1:0] rw, enab, mux_sel;
    logic       L_PC, I_PC, S11, S10, L_IR, S_AL, sel_a, sel_b, halted;
    logic [2:0] reg_sel, state_o;
    logic [3:0] S_AF;

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t  sb_q[$];
    string tag_q[$];

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .flags(flags), .stall(stall),
        .rw(rw), .L_PC(L_PC), .I_PC(I_PC), .S11(S11), .S10(S10),
        .enab(enab), .reg_sel(reg_sel), .mux_sel(mux_sel), .L_IR(L_IR),
        .S_AL(S_AL), .S_AF(S_AF), .sel_a(sel_a), .sel_b(sel_b),
        .halted(halted), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input exp_t obs, input exp_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     tag, obs, exp, obs.state, exp.state);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            exp_t  o;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            o = '{state: state_o, rw: rw, l_pc: L_PC, i_pc: I_PC, s11: S11, s10: S10,
                  enab: enab, reg_sel: reg_sel, mux_sel: mux_sel, l_ir: L_IR,
                  s_al: S_AL, s_af: S_AF, sel_a: sel_a, sel_b: sel_b, halted: halted};
            check_eq(t, o, e);
        end
    end

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.state = st;
        e.halted = (st == S_HALT);
        return e;
    endfunction

    task automatic step(input string tag, input logic [7:0] i, input logic [1:0] f,
                        input logic s, input logic r, input exp_t e);
        @(posedge clk);
        #1;
        ir = i; flags = f; stall = s; rst_n = r;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Pushes the full expected cycle sequence of one instruction (not HLT)
    task automatic issue(input string tag, input logic [7:0] i, input logic [1:0] f,
                         input int unsigned n_stall);
        exp_t       e;
        logic [3:0] op;
        logic       take;
        op = i[7:4];
        e = blank(S_FETCH); e.l_ir = 1'b1; e.i_pc = 1'b1;
        step({tag, "/fetch"}, i, f, 1'b0, 1'b1, e);
        step({tag, "/decode"}, i, f, 1'b0, 1'b1, blank(S_DECODE));
        if ((op >= 4'h1 && op <= 4'h3) || (op >= 4'h6 && i[3])) begin
            e = blank(S_OPERAND); e.i_pc = 1'b1;
            step({tag, "/operand"}, i, f, 1'b0, 1'b1, e);
        end
        for (int unsigned k = 0; k < n_stall; k++)
            step({tag, "/stall"}, i, ~f, 1'b1, 1'b1, blank(S_EXEC));
        e = blank(S_EXEC);
        case (op)
            4'h0: if (i[3:0] == 4'h2) begin e.rw = 2'b10; e.l_pc = 1'b1; e.s11 = 1'b1; end
            4'h1: begin e.enab = 2'b01; e.reg_sel = i[2:0]; e.mux_sel = 2'b01; end
            4'h2: begin
                case (i[2:0])
                    3'd0: take = 1'b1;
                    3'd1: take = f[0];
                    3'd2: take = !f[0];
                    3'd3: take = f[1];
                    3'd4: take = !f[1];
                    default: take = 1'b0;
                endcase
                if (take) begin e.l_pc = 1'b1; e.s10 = 1'b1; end
            end
            4'h3: begin e.rw = 2'b01; e.l_pc = 1'b1; e.s10 = 1'b1; end
            4'h4: begin e.rw = 2'b01; e.enab = 2'b10; e.reg_sel = i[2:0]; end
            4'h5: begin e.rw = 2'b10; e.enab = 2'b01; e.reg_sel = i[2:0]; e.mux_sel = 2'b10; end
            default: begin
                e.s_af = op; e.sel_a = 1'b1; e.sel_b = i[3];
                if (!i[3]) begin e.enab = 2'b10; e.reg_sel = i[2:0]; end
            end
        endcase
        step({tag, "/exec"}, i, f, 1'b0, 1'b1, e);
        if (op >= 4'h6) begin
            e = blank(S_WB); e.s_af = op; e.sel_a = 1'b1; e.sel_b = i[3]; e.s_al = 1'b1;
            if (op != 4'h7) e.enab = 2'b01;
            step({tag, "/wb"}, i, f, 1'b0, 1'b1, e);
        end
    endtask

    initial begin
        exp_t e;
        for (int unsigned k = 0; k < 3; k++)
            step("reset", 8'h00, 2'b00, 1'b0, 1'b0, blank(S_RST));
        step("reset_release", 8'h00, 2'b00, 1'b0, 1'b1, blank(S_RST));

        issue("alu_reg_62", 8'h62, 2'b00, 0);
        issue("cmp_imm_78", 8'h78, 2'b00, 0);
        issue("jz_not_taken", 8'h21, 2'b00, 0);
        issue("jz_taken", 8'h21, 2'b01, 0);
        issue("jnc_taken", 8'h24, 2'b01, 0);
        issue("jmp_never", 8'h27, 2'b11, 0);
        issue("call_30", 8'h30, 2'b00, 0);
        issue("mvi_stall", 8'h13, 2'b00, 2);
        issue("jz_stall", 8'h21, 2'b01, 3);
        issue("nop", 8'h00, 2'b00, 0);
        issue("ret", 8'h02, 2'b00, 0);
        issue("push_45", 8'h45, 2'b00, 0);
        issue("pop_56", 8'h56, 2'b00, 1);
        issue("alu_imm_ad", 8'hAD, 2'b00, 0);
        issue("alu_reg_f7", 8'hF7, 2'b00, 0);

        e = blank(S_FETCH); e.l_ir = 1'b1; e.i_pc = 1'b1;
        step("hlt/fetch", 8'h01, 2'b00, 1'b0, 1'b1, e);
        step("hlt/decode", 8'h01, 2'b00, 1'b0, 1'b1, blank(S_DECODE));
        for (int unsigned k = 0; k < 20; k++)
            step("halt_hold", 8'h01, 2'b11, 1'b0, 1'b1, blank(S_HALT));
        for (int unsigned k = 0; k < 2; k++)
            step("halt_reset", 8'h01, 2'b00, 1'b0, 1'b0, blank(S_RST));
        step("halt_release", 8'h00, 2'b00, 1'b0, 1'b1, blank(S_RST));
        issue("post_halt_push", 8'h41, 2'b00, 0);

        // Reset asserted mid-instruction clears strobes at once
        e = blank(S_FETCH); e.l_ir = 1'b1; e.i_pc = 1'b1;
        step("midreset/fetch", 8'h62, 2'b00, 1'b0, 1'b1, e);
        step("midreset/decode", 8'h62, 2'b00, 1'b0, 1'b1, blank(S_DECODE));
        step("midreset/exec", 8'h62, 2'b00, 1'b0, 1'b0, blank(S_RST));
        step("midreset/release", 8'h62, 2'b00, 1'b0, 1'b1, blank(S_RST));
        issue("post_midreset", 8'h62, 2'b00, 0);

        for (int unsigned k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
